// File: rtl/rx_packet_ctrl_if.sv
// Receive-control bus: decoder/shift-register side signals in, FIFO/status side signals out.
// The master drives the line-side inputs; the controller is the slave.
interface rx_packet_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             d_edge;
    logic             eop;
    logic             shift_enable;
    logic [7:0]       rcv_data;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic             clr_shift;
    logic [CNT_W-1:0] byte_count;

    modport master (
        output d_edge, eop, shift_enable, rcv_data,
        input  rcving, w_enable, r_error, clr_shift, byte_count
    );

    modport slave (
        input  d_edge, eop, shift_enable, rcv_data,
        output rcving, w_enable, r_error, clr_shift, byte_count
    );
endinterface

// File: rtl/rx_packet_ctrl.sv
// USB full-speed receive control FSM: SYNC validation, byte framing, FIFO write strobes, error flags.
// Optional RX_PID_CHECK_EN: first data byte must carry a valid PID (low nibble == ~high nibble).
module rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = 7
) (
    input  logic            clk,
    input  logic            n_rst,
    rx_packet_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SYNC_WAIT, SYNC_CHK, RECV, STORE, EOP_WAIT, ERR_WAIT, EIDLE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    state_t           state, next_state;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_count;
    logic             r_error, clr_shift, eop_seen;
    logic             start, strobe_eop, byte_done, at_max, pid_bad, rcving, w_enable;

    assign rcving     = (state != IDLE) && (state != EIDLE);
    assign start      = !rcving && bus.d_edge;
    assign strobe_eop = bus.eop & bus.shift_enable;
    // eop wins over a byte completing on the same strobe
    assign byte_done  = bus.shift_enable & ~bus.eop & (bit_cnt == 3'd7);
    assign at_max     = (byte_count == MAX_CNT);

`ifdef RX_PID_CHECK_EN
    assign pid_bad = (state == STORE) && (byte_count == '0) &&
                     (bus.rcv_data[3:0] != ~bus.rcv_data[7:4]);
`else
    assign pid_bad = 1'b0;
`endif

    assign w_enable = (state == STORE) && !pid_bad;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, EIDLE: if (bus.d_edge) next_state = SYNC_WAIT;
            SYNC_WAIT: begin
                if (strobe_eop)     next_state = ERR_WAIT;
                else if (byte_done) next_state = SYNC_CHK;
            end
            SYNC_CHK: next_state = (bus.rcv_data == SYNC_BYTE) ? RECV : ERR_WAIT;
            RECV: begin
                if (strobe_eop)     next_state = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_WAIT;
                else if (byte_done) next_state = at_max ? ERR_WAIT : STORE;
            end
            STORE: next_state = pid_bad ? ERR_WAIT : RECV;
            EOP_WAIT: begin
                if (bus.shift_enable && !bus.eop)
                    next_state = (byte_count == '0) ? EIDLE : IDLE;
            end
            ERR_WAIT: begin
                if (bus.shift_enable && !bus.eop && eop_seen) next_state = EIDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt    <= '0;
            byte_count <= '0;
            r_error    <= 1'b0;
            clr_shift  <= 1'b0;
            eop_seen   <= 1'b0;
        end else begin
            clr_shift <= start;

            if (start)                          bit_cnt <= '0;
            else if (rcving && bus.shift_enable) bit_cnt <= bit_cnt + 3'd1;

            if (start)                   byte_count <= '0;
            else if (w_enable && !at_max) byte_count <= byte_count + 1'b1;

            // an empty packet with a clean EOP is still an error
            if (start)
                r_error <= 1'b0;
            else if (next_state == ERR_WAIT || (state == EOP_WAIT && next_state == EIDLE))
                r_error <= 1'b1;

            // ERR_WAIT must see eop rise before its falling strobe counts as packet end
            if (state != ERR_WAIT) eop_seen <= bus.eop;
            else                   eop_seen <= eop_seen | bus.eop;
        end
    end

    assign bus.rcving     = rcving;
    assign bus.w_enable   = w_enable;
    assign bus.r_error    = r_error;
    assign bus.clr_shift  = clr_shift;
    assign bus.byte_count = byte_count;
endmodule
